pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the MicroUAZ core: drives the instruction-memory address bus each cycle and selects next-address, absolute jump, conditional jump, subroutine call/return, or halt. It replaces the fixed 9-bit/3-flag jump unit. New capabilities are a selectable flag with polarity, a return-address stack, stall, halt, and sticky fault reporting. It sits between the control decoder (op, condition, target) and the program memory address port.

## Interface
- ADDR_W, 9, program-counter/address width
- TGT_W, 8, jump-target width; must be ≤ ADDR_W
- NFLAGS, 3, number of ALU flags presented
- STACK_DEPTH, 4, return-stack entries (≥ 1)
- RESET_ADDR, 0, PC value after reset
- i_Clk  in  1  clock; all state changes on rising edge
- i_Reset  in  1  synchronous active-high reset
- i_Enable  in  1  1 = advance this cycle; 0 = stall, all state held
- i_Op  in  3  operation: 000 NEXT, 001 JMP, 010 JCOND, 011 CALL, 100 RET, 101 HALT, 110 JREL, 111 JRELC
- i_Cond_Sel  in  max(1,$clog2(NFLAGS))  flag index for conditional ops
- i_Cond_Inv  in  1  1 = branch when selected flag is 0
- i_Flags  in  NFLAGS  ALU flags
- i_Target  in  TGT_W  absolute target (zero-extended) or relative offset (signed)
- o_Addressinstruction_Bus  out  ADDR_W  current PC
- o_Stack_Depth  out  $clog2(STACK_DEPTH+1)  occupied entries
- o_Stack_Full / o_Stack_Empty  out  1 each  depth == STACK_DEPTH / depth == 0
- o_Halted  out  1  in HALTED state
- o_Fault  out  1  sticky: overflow, underflow or illegal op seen
- o_Fault_Code  out  2  first fault cause: 01 overflow, 10 underflow, 11 illegal op; 00 none

## Operation
- States: RUN, HALTED. Reset → RUN. HALT in RUN with i_Enable=1 → HALTED. HALTED exits only on reset; PC is frozen and ops are ignored.
- take = (i_Cond_Sel < NFLAGS) ? i_Flags[i_Cond_Sel] ^ i_Cond_Inv : 0.
- inc = PC+1, modulo 2^ADDR_W (0x1FF → 0x000 for the default width).
- NEXT: PC ← inc. JMP: PC ← zext(i_Target). JCOND: PC ← take ? zext(i_Target) : inc.
- CALL: if not full, push inc and set PC ← zext(i_Target). If full, PC ← inc with no push and fault 01.
- RET: if not empty, PC ← top and pop. If empty, PC ← inc and fault 10.
- JREL/JRELC: see Configuration.
- Fault: o_Fault sets on the first fault and stays set. o_Fault_Code latches the first cause only. Both clear only on reset. Faults never halt the sequencer.
- i_Enable=0: PC, stack, state and fault registers all hold.

## Timing
- All outputs are registered. The new PC is visible one cycle after the edge that samples the op. Latency is 1 for every op.
- Push/pop and depth update occur on the same edge as the PC update. o_Stack_Full, o_Stack_Empty and o_Stack_Depth are updated the same cycle.
- Reset values: PC = RESET_ADDR, depth 0, o_Stack_Empty 1, o_Stack_Full 0, o_Halted 0, o_Fault 0, o_Fault_Code 00.
- Reset mid-call: the stack is discarded. Reset takes priority over i_Enable and all ops.
- Back-to-back CALL/RET on consecutive cycles are supported with no bubble.

## Configuration
- PC_REL_JUMP_EN defined:
  - JREL: PC ← PC + sext(i_Target), modulo 2^ADDR_W.
  - JRELC: PC ← take ? PC + sext(i_Target) : inc.
- PC_REL_JUMP_EN undefined: ops 110/111 act as NEXT and raise fault 11 (illegal op).

## Structure
- Package pc_seq_pkg holds:
  - op encoding constants (OP_NEXT … OP_JRELC)
  - state typedef (ST_RUN, ST_HALTED)
  - fault-code constants
- Sub-module pc_ret_stack is a parametrised LIFO (push, pop, top, depth, full, empty). It is synchronous and uses the same reset.

## Test plan
- Reset, then 3 NEXT → PC 0,1,2,3. Force PC to 0x1FF via JMP (TGT_W=9 build) then NEXT → 0x000.
- i_Flags=3'b010, JCOND Sel=1 Inv=0, target 0x40 → PC 0x40. Same with Inv=1 → PC+1. Sel=3 (out of range) → PC+1.
- At PC 0x10: CALL 0x20 → PC 0x20, depth 1. RET → PC 0x11, depth 0, o_Stack_Empty 1.
- Overflow: 5 nested CALLs with depth 4 → 5th gives PC+1, o_Fault 1, code 01. A later RET-on-empty keeps code 01.
- i_Enable=0 for 3 cycles with JMP 0x55 on i_Op → PC unchanged. HALT → o_Halted 1 and PC frozen under any op until i_Reset.
- With PC_REL_JUMP_EN: PC 0x08, JREL 0xFE → 0x06. Without it: same stimulus → PC 0x09, code 11.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared op encodings, FSM state type and fault codes for the MicroUAZ PC sequencer.
package pc_seq_pkg;

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_JCOND = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b101;
    localparam logic [2:0] OP_JREL  = 3'b110;
    localparam logic [2:0] OP_JRELC = 3'b111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UNF  = 2'b10;
    localparam logic [1:0] FLT_ILL  = 2'b11;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the PC sequencer. Push/pop are ignored when full/empty;
// the top entry is readable combinationally from the registered storage.
module pc_ret_stack #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] count;
    logic [DW-1:0] top_idx;

    assign full    = (count == DW'(DEPTH));
    assign empty   = (count == '0);
    assign depth   = count;
    assign top_idx = count - DW'(1);
    assign top     = empty ? '0 : mem[top_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + DW'(1);
        end else if (pop && !empty) begin
            count <= count - DW'(1);
        end
    end

    // Storage needs no reset: entries above the count are never read.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[count[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next/jump/cond-jump/call/return/halt with sticky faults.
// Relative jumps (ops 110/111) exist only when PC_REL_JUMP_EN is defined; otherwise they fault as illegal.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int TGT_W       = 8,
    parameter int NFLAGS      = 3,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0,
    localparam int CS_W       = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int SD_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    input  logic [2:0]        i_Op,
    input  logic [CS_W-1:0]   i_Cond_Sel,
    input  logic              i_Cond_Inv,
    input  logic [NFLAGS-1:0] i_Flags,
    input  logic [TGT_W-1:0]  i_Target,
    output logic [ADDR_W-1:0] o_Addressinstruction_Bus,
    output logic [SD_W-1:0]   o_Stack_Depth,
    output logic              o_Stack_Full,
    output logic              o_Stack_Empty,
    output logic              o_Halted,
    output logic              o_Fault,
    output logic [1:0]        o_Fault_Code
);

    pc_state_t         state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] abs_tgt;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] stk_top;
    logic              take;
    logic              active;
    logic              push;
    logic              pop;
    logic              fault_now;
    logic [1:0]        cause;

    assign active  = i_Enable && (state == ST_RUN);
    assign inc     = pc + ADDR_W'(1);
    assign abs_tgt = ADDR_W'(i_Target);
    assign take    = ({1'b0, i_Cond_Sel} < (CS_W + 1)'(NFLAGS)) ? (i_Flags[i_Cond_Sel] ^ i_Cond_Inv) : 1'b0;

`ifdef PC_REL_JUMP_EN
    logic [ADDR_W-1:0] rel_pc;
    assign rel_pc = pc + ADDR_W'($signed(i_Target));
`endif

    always_comb begin
        next_pc   = inc;
        push      = 1'b0;
        pop       = 1'b0;
        fault_now = 1'b0;
        cause     = FLT_NONE;
        case (i_Op)
            OP_NEXT:  next_pc = inc;
            OP_JMP:   next_pc = abs_tgt;
            OP_JCOND: next_pc = take ? abs_tgt : inc;
            OP_CALL: begin
                if (!o_Stack_Full) begin
                    push    = active;
                    next_pc = abs_tgt;
                end else begin
                    fault_now = 1'b1;
                    cause     = FLT_OVF;
                end
            end
            OP_RET: begin
                if (!o_Stack_Empty) begin
                    pop     = active;
                    next_pc = stk_top;
                end else begin
                    fault_now = 1'b1;
                    cause     = FLT_UNF;
                end
            end
            OP_HALT:  next_pc = pc;
`ifdef PC_REL_JUMP_EN
            OP_JREL:  next_pc = rel_pc;
            OP_JRELC: next_pc = take ? rel_pc : inc;
`else
            OP_JREL, OP_JRELC: begin
                fault_now = 1'b1;
                cause     = FLT_ILL;
            end
`endif
            default:  next_pc = inc;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state        <= ST_RUN;
            pc           <= ADDR_W'(RESET_ADDR);
            o_Fault      <= 1'b0;
            o_Fault_Code <= FLT_NONE;
        end else if (active) begin
            pc <= next_pc;
            if (i_Op == OP_HALT) state <= ST_HALTED;
            // Only the first cause is kept; later faults leave the code alone.
            if (fault_now && !o_Fault) begin
                o_Fault      <= 1'b1;
                o_Fault_Code <= cause;
            end
        end
    end

    pc_ret_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (i_Clk),
        .reset     (i_Reset),
        .push      (push),
        .pop       (pop),
        .push_data (inc),
        .top       (stk_top),
        .depth     (o_Stack_Depth),
        .full      (o_Stack_Full),
        .empty     (o_Stack_Empty)
    );

    assign o_Addressinstruction_Bus = pc;
    assign o_Halted                 = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (9-bit targets): directed vector table, hand sequences, and random run vs a queue-based model.
module tb_pc_sequencer;

    localparam int ADDR_W = 9;
    localparam int TGT_W  = 9;
    localparam int NF     = 3;
    localparam int SD     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic [1:0]       sel;
    logic             inv;
    logic [NF-1:0]    flags;
    logic [TGT_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_o;
    logic [2:0]       depth_o;
    logic             full_o, empty_o, halted_o, fault_o;
    logic [1:0]       code_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W(ADDR_W), .TGT_W(TGT_W), .NFLAGS(NF), .STACK_DEPTH(SD), .RESET_ADDR(0)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Op(op), .i_Cond_Sel(sel),
        .i_Cond_Inv(inv), .i_Flags(flags), .i_Target(tgt),
        .o_Addressinstruction_Bus(pc_o), .o_Stack_Depth(depth_o), .o_Stack_Full(full_o),
        .o_Stack_Empty(empty_o), .o_Halted(halted_o), .o_Fault(fault_o), .o_Fault_Code(code_o)
    );

    // Reference model: plain integer PC plus a queue standing in for the return stack.
    int m_pc;
    int m_stk[$];
    bit m_halt, m_fault;
    int m_code;

    function automatic void m_raise(int c);
        if (!m_fault) begin
            m_fault = 1;
            m_code  = c;
        end
    endfunction

    function automatic void m_reset();
        m_pc = 0; m_stk.delete(); m_halt = 0; m_fault = 0; m_code = 0;
    endfunction

    function automatic void m_step(bit e, int o, int s, bit iv, int f, int t);
        int nx, off;
        bit tk;
        if (m_halt || !e) return;
        tk = (s < NF) ? (((f >> s) & 1) != iv) : 0;
        nx = (m_pc + 1) % 512;
        off = (t >= 256) ? t - 512 : t;
        case (o)
            0: m_pc = nx;
            1: m_pc = t;
            2: m_pc = tk ? t : nx;
            3: if (m_stk.size() < SD) begin m_stk.push_back(nx); m_pc = t; end
               else begin m_pc = nx; m_raise(1); end
            4: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
               else begin m_pc = nx; m_raise(2); end
            5: m_halt = 1;
            default: begin
`ifdef PC_REL_JUMP_EN
                if (o == 6 || tk) m_pc = (m_pc + off + 512) % 512;
                else m_pc = nx;
`else
                m_pc = nx; m_raise(3);
`endif
            end
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, int e_pc, int e_d, bit e_h, bit e_f, int e_c);
        check({tag, " pc"}, pc_o, e_pc);
        check({tag, " depth"}, depth_o, e_d);
        check({tag, " empty"}, empty_o, e_d == 0);
        check({tag, " full"}, full_o, e_d == SD);
        check({tag, " halted"}, halted_o, e_h);
        check({tag, " fault"}, fault_o, e_f);
        check({tag, " code"}, code_o, e_c);
    endtask

    task automatic drive(bit e, int o, int s, bit iv, int f, int t);
        en = e; op = 3'(o); sel = 2'(s); inv = iv; flags = 3'(f); tgt = 9'(t);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0); rst = 1'b0;
    endtask

    typedef struct {
        bit e; int o; int s; bit iv; int f; int t;
        int pc; int d; bit h; bit flt; int code;
    } vec_t;

    function automatic vec_t v(bit e, int o, int s, bit iv, int f, int t,
                               int pc, int d, bit h, bit flt, int code);
        vec_t r;
        r.e = e; r.o = o; r.s = s; r.iv = iv; r.f = f; r.t = t;
        r.pc = pc; r.d = d; r.h = h; r.flt = flt; r.code = code;
        return r;
    endfunction

    vec_t tbl[$];
    int rel_pc;

    initial begin
`ifdef PC_REL_JUMP_EN
        rel_pc = 'h06;
`else
        rel_pc = 'h09;
`endif
        tbl.push_back(v(1, 0, 0, 0, 0, 0,     'h001, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,     'h002, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,     'h003, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 'h1FF, 'h1FF, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,     'h000, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 'h010, 'h010, 0, 0, 0, 0));
        tbl.push_back(v(1, 2, 1, 0, 2, 'h040, 'h040, 0, 0, 0, 0));
        tbl.push_back(v(1, 2, 1, 1, 2, 'h080, 'h041, 0, 0, 0, 0));
        tbl.push_back(v(1, 2, 3, 0, 7, 'h080, 'h042, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 'h010, 'h010, 0, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h020, 'h020, 1, 0, 0, 0));
        tbl.push_back(v(1, 4, 0, 0, 0, 0,     'h011, 0, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h030, 'h030, 1, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h031, 'h031, 2, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h032, 'h032, 3, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h033, 'h033, 4, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h034, 'h034, 4, 0, 1, 1));
        tbl.push_back(v(1, 4, 0, 0, 0, 0,     'h033, 3, 0, 1, 1));
        tbl.push_back(v(1, 4, 0, 0, 0, 0,     'h032, 2, 0, 1, 1));
        tbl.push_back(v(1, 4, 0, 0, 0, 0,     'h031, 1, 0, 1, 1));
        tbl.push_back(v(1, 4, 0, 0, 0, 0,     'h012, 0, 0, 1, 1));
        tbl.push_back(v(1, 4, 0, 0, 0, 0,     'h013, 0, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 'h055, 'h013, 0, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 'h055, 'h013, 0, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 'h055, 'h013, 0, 0, 1, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 'h008, 'h008, 0, 0, 1, 1));
        tbl.push_back(v(1, 6, 0, 0, 0, 'h1FE, rel_pc, 0, 0, 1, 1));
        tbl.push_back(v(1, 5, 0, 0, 0, 0,     rel_pc, 0, 1, 1, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 'h055, rel_pc, 0, 1, 1, 1));
        tbl.push_back(v(1, 3, 0, 0, 0, 'h077, rel_pc, 0, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,     rel_pc, 0, 1, 1, 1));

        rst = 1'b0; en = 1'b0; op = '0; sel = '0; inv = 1'b0; flags = '0; tgt = '0;
        do_reset();
        check_all("reset", 0, 0, 0, 0, 0);

        foreach (tbl[i])
        begin
            drive(tbl[i].e, tbl[i].o, tbl[i].s, tbl[i].iv, tbl[i].f, tbl[i].t);
            check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].d, tbl[i].h, tbl[i].flt, tbl[i].code);
        end

        // Reset while halted with a stack in use earlier: everything returns to reset state.
        do_reset();
        check_all("halt_exit", 0, 0, 0, 0, 0);

        // Reset mid-call discards the stack; a following RET sees an empty stack.
        drive(1, 3, 0, 0, 0, 'h100);
        drive(1, 3, 0, 0, 0, 'h120);
        check_all("call2", 'h120, 2, 0, 0, 0);
        rst = 1'b1; drive(1, 3, 0, 0, 0, 'h140); rst = 1'b0;
        check_all("rst_midcall", 0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0);
        check_all("ret_empty", 1, 0, 0, 1, 2);

        // Relative jump on a clean fault register.
        do_reset();
        drive(1, 1, 0, 0, 0, 'h008);
        drive(1, 6, 0, 0, 0, 'h1FE);
`ifdef PC_REL_JUMP_EN
        check_all("jrel", 'h006, 0, 0, 0, 0);
        drive(1, 7, 0, 1, 1, 'h004);
        check_all("jrelc_nt", 'h007, 0, 0, 0, 0);
`else
        check_all("jrel_ill", 'h009, 0, 0, 1, 3);
        drive(1, 7, 0, 0, 1, 'h004);
        check_all("jrelc_ill", 'h00A, 0, 0, 1, 3);
`endif

        // Random run against the model.
        do_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            bit r, e, iv;
            int o, s, f, t;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 99) < 85);
            o  = $urandom_range(0, 7);
            if (o == 5 && $urandom_range(0, 3) != 0) o = 0;
            s  = $urandom_range(0, 3);
            iv = 1'($urandom_range(0, 1));
            f  = $urandom_range(0, 7);
            t  = $urandom_range(0, 511);
            rst = r;
            drive(e, o, s, iv, f, t);
            rst = 1'b0;
            if (r) m_reset();
            else m_step(e, o, s, iv, f, t);
            check_all($sformatf("rnd%0d", n), m_pc, m_stk.size(), m_halt, m_fault, m_code);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
